rv32_fetch: RTL and testbench
=============================

// Module: rv32_fetch
// PURPOSE
// - Instruction fetch stage, upstream of rv32_decode; drives its instr_i, pc_i, pc_next_i.
// - Owns the fetch PC and a request/response instruction-memory port (one outstanding request).
// - Owns the IF/ID pipeline register, with stall (hold), flush (bubble) and redirect from execute.
// PARAMETERS
// - RESET_PC   32'h0000_0000  fetch address of the first request after reset
// - NOP_INSTR  32'h0000_0013  bubble encoding (addi x0,x0,0) loaded into IF/ID
// PORTS
// - clk_i         in   1   clock; all state on posedge
// - rst_n_i       in   1   asynchronous, active-low reset
// - stall_f_i     in   1   hazard unit: do not issue a new imem request
// - stall_d_i     in   1   hazard unit: hold IF/ID contents
// - flush_d_i     in   1   hazard unit: load bubble into IF/ID (priority over stall_d_i)
// - pc_src_i      in   1   redirect (taken branch/jump/trap) this cycle
// - pc_target_i   in   32  redirect address, valid when pc_src_i=1
// - imem_req_o    out  1   request valid
// - imem_addr_o   out  32  request address (= fetch PC)
// - imem_ready_i  in   1   memory accepts request this cycle (req & ready = handshake)
// - imem_valid_i  in   1   response valid; never in the same cycle as its acceptance
// - imem_rdata_i  in   32  response instruction word
// - instr_o       out  32  IF/ID instruction
// - pc_o          out  32  IF/ID PC of instr_o
// - pc_next_o     out  32  IF/ID pc_o + 4
// BEHAVIOUR
// - Reset: state IDLE, fetch PC = RESET_PC, discard=0, buffer empty; instr_o=NOP_INSTR,
//   pc_o=0, pc_next_o=0; imem_req_o=0 while rst_n_i low.
// - FSM IDLE: -> REQ next cycle (only entered from reset).
// - REQ: imem_req_o = !stall_f_i, imem_addr_o = fetch PC; on handshake -> WAIT.
// - WAIT: on imem_valid_i: discard=1 -> drop word, discard<=0, -> REQ;
//   else if stall_d_i -> capture word in 1-entry buffer, -> HOLD; else deliver, -> REQ.
// - HOLD: imem_req_o=0; when stall_d_i=0 deliver buffered word, -> REQ.
// - Deliver: IF/ID <= {word, fetch PC, fetch PC+4}; fetch PC <= fetch PC+4 (mod 2^32, wraps).
// - Redirect (pc_src_i=1), any state: fetch PC <= pc_target_i; WAIT with no response this
//   cycle -> discard<=1; HOLD -> buffer cleared, -> REQ; response arriving this same cycle
//   is dropped (redirect wins), -> REQ. No delivery in a redirect cycle.
// - Redirect during REQ with handshake same cycle: request issued at old PC -> WAIT, discard<=1.
// - IF/ID priority: flush_d_i (NOP_INSTR, pc 0, pc_next 0) > stall_d_i (hold) > deliver >
//   bubble (no word delivered and not stalled -> NOP_INSTR, pc 0, pc_next 0).
// - Latency: one cycle from response (or stall release in HOLD) to IF/ID outputs.
// - imem_addr_o bits [1:0] always 0; pc_target_i[1:0] assumed 0 by execute, forced to 0 here.
// - Reset asserted mid-request: state/IF/ID return to reset values immediately; any late
//   response after release is ignored because state is IDLE/REQ, not WAIT.
// STRUCTURE
// - Fetch-state enum {IDLE, REQ, WAIT, HOLD} and NOP_INSTR constant go in defines_header.svh.
// - Sub-module rv32_f_instr_buffer: 1-entry holding register (load/clear/valid) used by HOLD.
// - Top holds FSM, fetch PC register, discard flag, IF/ID register.
// TESTING
// - Reset release, imem_ready_i=1, 1-cycle latency, words 0xA,0xB -> req addr 0x0 then 0x4;
//   instr_o=0xA/pc_o=0x0/pc_next_o=0x4, then 0xB/0x4/0x8; NOP_INSTR during gaps.
// - imem_ready_i low 3 cycles in REQ -> imem_req_o held 1, addr stable 0x0, IF/ID NOP.
// - pc_src_i=1, pc_target_i=0x100 while WAIT at 0x8 -> late response dropped, next req 0x100,
//   no instr with pc_o=0x8 ever appears.
// - stall_d_i=1 when response 0xC arrives -> IF/ID unchanged, req low; release ->
//   instr_o=0xC next cycle, following req issued.
// - flush_d_i=1 and stall_d_i=1 together -> instr_o=NOP_INSTR, pc_o=0, pc_next_o=0.
// - rst_n_i low during WAIT -> outputs reset async; post-release stray imem_valid_i ignored,
//   first req addr = RESET_PC; fetch PC 0xFFFF_FFFC delivers pc_next_o=0x0 (wrap).

Source files
------------

// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch stage.
package rv32_fetch_pkg;

    localparam int XLEN = 32;

    // Bubble encoding: addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0013;

    localparam logic [XLEN-1:0] PC_INCR = 32'd4;

    // IDLE is only reachable through reset; REQ issues, WAIT awaits the
    // response, HOLD parks a response that arrived while decode was stalled.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/rv32_f_instr_buffer.sv
// One-entry holding register for a fetched word that decode could not take yet.
module rv32_f_instr_buffer
    import rv32_fetch_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            valid
);

    // Occupancy flag; clear wins over load.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // Payload is qualified by valid, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (load) begin
            rdata <= wdata;
        end
    end

endmodule

// File: rtl/rv32_fetch.sv
// RV32 instruction fetch: fetch PC, single-outstanding imem port, IF/ID register.
module rv32_fetch
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_f_i,
    input  logic        stall_d_i,
    input  logic        flush_d_i,
    input  logic        pc_src_i,
    input  logic [31:0] pc_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_next_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         discard_q, discard_d;
    logic         req_c;
    logic         deliver;
    logic [31:0]  deliver_word;
    logic         buf_load, buf_clear, buf_valid;
    logic [31:0]  buf_word;

    rv32_f_instr_buffer u_buf (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load    (buf_load),
        .clear   (buf_clear),
        .wdata   (imem_rdata_i),
        .rdata   (buf_word),
        .valid   (buf_valid)
    );

    assign imem_req_o  = req_c;
    assign imem_addr_o = fetch_pc_q;

    // FSM state, fetch PC and stale-response flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= align_word(RESET_PC);
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    // Next-state, request, delivery and redirect handling.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        discard_d    = discard_q;
        req_c        = 1'b0;
        deliver      = 1'b0;
        deliver_word = imem_rdata_i;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                req_c = !stall_f_i;
                if (req_c && imem_ready_i) begin
                    // A redirect in the accept cycle leaves the request at
                    // the old PC in flight; its response must be dropped.
                    state_d   = WAIT;
                    discard_d = pc_src_i;
                end
            end
            WAIT: begin
                if (pc_src_i) begin
                    if (imem_valid_i) begin
                        discard_d = 1'b0;
                        state_d   = REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_valid_i) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = REQ;
                    end else if (stall_d_i) begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        deliver = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            HOLD: begin
                if (pc_src_i) begin
                    buf_clear = 1'b1;
                    state_d   = REQ;
                end else if (!buf_valid) begin
                    // Empty buffer in HOLD cannot occur; recover by refetching.
                    state_d = REQ;
                end else if (!stall_d_i) begin
                    deliver      = 1'b1;
                    deliver_word = buf_word;
                    buf_clear    = 1'b1;
                    state_d      = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pc_src_i) begin
            fetch_pc_d = align_word(pc_target_i);
        end else if (deliver) begin
            fetch_pc_d = fetch_pc_q + PC_INCR;
        end
    end

    // IF/ID register: flush > stall > deliver > bubble.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            instr_o   <= NOP_INSTR;
            pc_o      <= '0;
            pc_next_o <= '0;
        end else if (flush_d_i) begin
            instr_o   <= NOP_INSTR;
            pc_o      <= '0;
            pc_next_o <= '0;
        end else if (stall_d_i) begin
            instr_o   <= instr_o;
            pc_o      <= pc_o;
            pc_next_o <= pc_next_o;
        end else if (deliver) begin
            instr_o   <= deliver_word;
            pc_o      <= fetch_pc_q;
            pc_next_o <= fetch_pc_q + PC_INCR;
        end else begin
            instr_o   <= NOP_INSTR;
            pc_o      <= '0;
            pc_next_o <= '0;
        end
    end

endmodule

// File: tb/tb_rv32_fetch.sv
// Self-checking bench for rv32_fetch: directed scenarios, then randomized traffic
// against a word-level model of the fetch stream.
module tb_rv32_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        stall_f_i, stall_d_i, flush_d_i, pc_src_i;
    logic [31:0] pc_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i, imem_valid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o, pc_o, pc_next_o;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk_i = ~clk_i;

    rv32_fetch dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .stall_f_i    (stall_f_i),
        .stall_d_i    (stall_d_i),
        .flush_d_i    (flush_d_i),
        .pc_src_i     (pc_src_i),
        .pc_target_i  (pc_target_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ready_i (imem_ready_i),
        .imem_valid_i (imem_valid_i),
        .imem_rdata_i (imem_rdata_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .pc_next_o    (pc_next_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                              input logic [31:0] en);
        check_eq({tag, ".instr"},   instr_o,   ei);
        check_eq({tag, ".pc"},      pc_o,      ep);
        check_eq({tag, ".pc_next"}, pc_next_o, en);
    endtask

    // Random-phase model: one request in flight at most, tracked as words, not states.
    int          out_cnt, lat;
    bit          out_stale, held, exp_req, got_resp, good, do_deliver;
    logic [31:0] held_word, dw, w, exp_pc, m_instr, m_pc, m_pcn;

    initial begin
        rst_n_i = 1'b0; stall_f_i = 0; stall_d_i = 0; flush_d_i = 0; pc_src_i = 0;
        pc_target_i = '0; imem_ready_i = 0; imem_valid_i = 0; imem_rdata_i = '0;
        cyc(); cyc();
        #1;
        check_eq("rst.req", 32'(imem_req_o), 32'd0);
        check_ifid("rst", NOP, 32'h0, 32'h0);
        rst_n_i = 1'b1;
        #1 check_eq("idle.req", 32'(imem_req_o), 32'd0);
        cyc();

        // Memory not ready for three cycles: request held at 0x0.
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("nrdy.req", 32'(imem_req_o), 32'd1);
            check_eq("nrdy.addr", imem_addr_o, 32'h0);
            check_eq("nrdy.instr", instr_o, NOP);
            cyc();
        end
        imem_ready_i = 1;
        #1 check_eq("a.addr", imem_addr_o, 32'h0);
        cyc();
        imem_ready_i = 0; imem_valid_i = 1; imem_rdata_i = 32'hA;
        #1;
        check_eq("a.wait_req", 32'(imem_req_o), 32'd0);
        check_eq("a.gap", instr_o, NOP);
        cyc();
        imem_valid_i = 0; imem_ready_i = 1;
        #1;
        check_ifid("a", 32'hA, 32'h0, 32'h4);
        check_eq("b.addr", imem_addr_o, 32'h4);
        cyc();
        imem_ready_i = 0; imem_valid_i = 1; imem_rdata_i = 32'hB;
        #1 check_eq("b.gap", instr_o, NOP);
        cyc();
        imem_valid_i = 0;
        #1;
        check_ifid("b", 32'hB, 32'h4, 32'h8);
        check_eq("c.addr", imem_addr_o, 32'h8);

        // Redirect while waiting at 0x8: late response dropped.
        imem_ready_i = 1;
        cyc();
        imem_ready_i = 0; pc_src_i = 1; pc_target_i = 32'h100;
        #1 check_eq("redir.req", 32'(imem_req_o), 32'd0);
        cyc();
        pc_src_i = 0; imem_valid_i = 1; imem_rdata_i = 32'hDEAD_BEEF;
        cyc();
        imem_valid_i = 0;
        #1;
        check_ifid("redir.drop", NOP, 32'h0, 32'h0);
        check_eq("redir.addr", imem_addr_o, 32'h100);
        imem_ready_i = 1;
        cyc();
        imem_ready_i = 0; imem_valid_i = 1; imem_rdata_i = 32'h111;
        cyc();
        imem_valid_i = 0;
        #1;
        check_ifid("tgt", 32'h111, 32'h100, 32'h104);

        // Decode stall when 0xC arrives: buffered, released later.
        stall_d_i = 1; imem_ready_i = 1;
        cyc();
        imem_ready_i = 0; imem_valid_i = 1; imem_rdata_i = 32'hC;
        cyc();
        imem_valid_i = 0;
        #1;
        check_eq("hold.req", 32'(imem_req_o), 32'd0);
        check_ifid("hold", 32'h111, 32'h100, 32'h104);
        cyc();
        #1 check_eq("hold2.req", 32'(imem_req_o), 32'd0);
        stall_d_i = 0;
        cyc();
        #1;
        check_ifid("rel", 32'hC, 32'h104, 32'h108);
        check_eq("rel.req", 32'(imem_req_o), 32'd1);
        check_eq("rel.addr", imem_addr_o, 32'h108);

        // Flush beats stall.
        stall_f_i = 1; stall_d_i = 1; flush_d_i = 1;
        #1 check_eq("stallf.req", 32'(imem_req_o), 32'd0);
        cyc();
        stall_f_i = 0; stall_d_i = 0; flush_d_i = 0;
        #1;
        check_ifid("flush", NOP, 32'h0, 32'h0);
        check_eq("flush.addr", imem_addr_o, 32'h108);

        // Redirect in the same cycle the request is accepted.
        imem_ready_i = 1; pc_src_i = 1; pc_target_i = 32'h200;
        cyc();
        imem_ready_i = 0; pc_src_i = 0; imem_valid_i = 1; imem_rdata_i = 32'h55;
        cyc();
        imem_valid_i = 0;
        #1;
        check_eq("hsredir.instr", instr_o, NOP);
        check_eq("hsredir.addr", imem_addr_o, 32'h200);

        // Reset while waiting.
        imem_ready_i = 1;
        cyc();
        imem_ready_i = 0; imem_valid_i = 1; imem_rdata_i = 32'h222;
        cyc();
        imem_valid_i = 0; imem_ready_i = 1; stall_d_i = 1;
        cyc();
        imem_ready_i = 0;
        #1 check_eq("prerst.instr", instr_o, 32'h222);
        rst_n_i = 0;
        #1;
        check_ifid("arst", NOP, 32'h0, 32'h0);
        check_eq("arst.req", 32'(imem_req_o), 32'd0);
        stall_d_i = 0;
        cyc();
        rst_n_i = 1; imem_valid_i = 1; imem_rdata_i = 32'h999;
        #1 check_eq("stray.req", 32'(imem_req_o), 32'd0);
        cyc();
        #1;
        check_eq("stray.req2", 32'(imem_req_o), 32'd1);
        check_eq("stray.addr", imem_addr_o, 32'h0);
        cyc();
        imem_valid_i = 0;
        #1;
        check_eq("stray.instr", instr_o, NOP);

        // Wrap at the top of the address space; unaligned target bits dropped.
        pc_src_i = 1; pc_target_i = 32'hFFFF_FFFF;
        cyc();
        pc_src_i = 0;
        #1 check_eq("wrap.addr", imem_addr_o, 32'hFFFF_FFFC);
        imem_ready_i = 1;
        cyc();
        imem_ready_i = 0; imem_valid_i = 1; imem_rdata_i = 32'h77;
        cyc();
        imem_valid_i = 0;
        #1;
        check_ifid("wrap", 32'h77, 32'hFFFF_FFFC, 32'h0);
        check_eq("wrap.next", imem_addr_o, 32'h0);

        // Randomized traffic against the word-level model.
        out_cnt = 0; lat = 0; out_stale = 0; held = 0; held_word = '0;
        exp_pc = 32'h0; m_instr = 32'h77; m_pc = 32'hFFFF_FFFC; m_pcn = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            got_resp     = (out_cnt != 0) && (lat == 0);
            imem_valid_i = got_resp;
            imem_rdata_i = $urandom;
            imem_ready_i = ($urandom_range(0, 2) != 0);
            stall_f_i    = ($urandom_range(0, 4) == 0);
            stall_d_i    = ($urandom_range(0, 3) == 0);
            flush_d_i    = ($urandom_range(0, 9) == 0);
            pc_src_i     = ($urandom_range(0, 11) == 0);
            pc_target_i  = $urandom;
            exp_req      = !stall_f_i && (out_cnt == 0) && !held;
            w            = imem_rdata_i;
            #1;
            check_eq("rnd.req", 32'(imem_req_o), 32'(exp_req));
            if (exp_req) check_eq("rnd.addr", imem_addr_o, exp_pc);

            good = got_resp && !out_stale && !pc_src_i;
            if (got_resp) out_cnt = 0;
            else if (out_cnt != 0) lat--;
            if (pc_src_i) begin
                out_stale = 1;
                held      = 0;
            end
            if (exp_req && imem_ready_i) begin
                out_cnt   = 1;
                lat       = $urandom_range(0, 3);
                out_stale = pc_src_i;
            end
            do_deliver = 0;
            dw         = '0;
            if (!pc_src_i) begin
                if (held && !stall_d_i) begin
                    do_deliver = 1; dw = held_word; held = 0;
                end else if (good && stall_d_i) begin
                    held = 1; held_word = w;
                end else if (good) begin
                    do_deliver = 1; dw = w;
                end
            end
            if (flush_d_i) begin
                m_instr = NOP; m_pc = 0; m_pcn = 0;
            end else if (!stall_d_i) begin
                if (do_deliver) begin
                    m_instr = dw; m_pc = exp_pc; m_pcn = exp_pc + 32'd4;
                end else begin
                    m_instr = NOP; m_pc = 0; m_pcn = 0;
                end
            end
            if (pc_src_i) exp_pc = pc_target_i & ~32'h3;
            else if (do_deliver) exp_pc = exp_pc + 32'd4;

            cyc();
            check_ifid("rnd", m_instr, m_pc, m_pcn);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
